// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan decoder: segment encodings
// (g..a, active-low), bit order, output FSM states and decode result type.
package seg7_pkg;

  localparam int NDIG_DEFAULT = 4;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0011000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       err;
  } seg_dec_t;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Frame output bus of the scan decoder, with the output FSM state for observation.
interface seg7_scan_decoder_if #(
  parameter int NDIG = 4
);
  import seg7_pkg::*;

  // Handshake: frame_vld stays high with value/blank/err stable until a clock
  // edge where frame_ack is also high; that edge transfers the frame.
  // frame_ack while frame_vld is low has no effect.
  logic [4*NDIG-1:0] value;
  logic [NDIG-1:0]   blank;
  logic [NDIG-1:0]   err;
  logic              frame_vld;
  logic              frame_ack;
  logic              overrun;
  out_state_e        state;

  modport master (
    output value, blank, err, frame_vld, overrun, state,
    input  frame_ack
  );

  modport slave (
    input  value, blank, err, frame_vld, overrun, state,
    output frame_ack
  );

endinterface

// File: rtl/seg7_pattern_decode.sv
// Maps one active-low segment pattern back to its hex nibble, flagging
// all-off patterns as blank and anything else unrecognised as an error.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output seg_dec_t   result
);

  always_comb begin
    result = '{nibble: 4'h0, blank: 1'b0, err: 1'b0};
    case (pattern)
      SEG_HEX_0: result.nibble = 4'h0;
      SEG_HEX_1: result.nibble = 4'h1;
      SEG_HEX_2: result.nibble = 4'h2;
      SEG_HEX_3: result.nibble = 4'h3;
      SEG_HEX_4: result.nibble = 4'h4;
      SEG_HEX_5: result.nibble = 4'h5;
      SEG_HEX_6: result.nibble = 4'h6;
      SEG_HEX_7: result.nibble = 4'h7;
      SEG_HEX_8: result.nibble = 4'h8;
      SEG_HEX_9: result.nibble = 4'h9;
      SEG_HEX_A: result.nibble = 4'hA;
      SEG_HEX_B: result.nibble = 4'hB;
      SEG_HEX_C: result.nibble = 4'hC;
      SEG_HEX_D: result.nibble = 4'hD;
      SEG_HEX_E: result.nibble = 4'hE;
      SEG_HEX_F: result.nibble = 4'hF;
      SEG_BLANK: result.blank  = 1'b1;
      default:   result.err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed 7-segment bus, captures each digit once it has been
// stable for STABLE samples, and hands complete frames out over a valid/ack pair.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG   = NDIG_DEFAULT,
  parameter int STABLE = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [6:0]      seg_n,
  input  logic [NDIG-1:0] dig_n,
  seg7_scan_decoder_if.master fr
);

  localparam int SELW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [6:0]      seg_s1, seg_s2, seg_prev;
  logic [NDIG-1:0] dig_s1, dig_s2, dig_prev;
  logic [7:0]      cnt, cnt_nx;
  logic            legal, hit;
  logic [SELW-1:0] sel;
  seg_dec_t        dec;

  logic            cap_vld;
  logic [SELW-1:0] cap_sel;
  seg_dec_t        cap_res;

  logic [4*NDIG-1:0] shadow_val, value_q;
  logic [NDIG-1:0]   shadow_blank, shadow_err, blank_q, err_q, seen;
  logic              frame_done, load, ovr_nx, overrun_q;
  out_state_e        state, state_nx;

  // Idle bus is all-ones, so synchronizers and the previous sample reset there.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seg_s1   <= '1;
      seg_s2   <= '1;
      seg_prev <= '1;
      dig_s1   <= '1;
      dig_s2   <= '1;
      dig_prev <= '1;
    end else begin
      seg_s1   <= seg_n;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      dig_s1   <= dig_n;
      dig_s2   <= dig_s1;
      dig_prev <= dig_s2;
    end
  end

  always_comb begin
    legal = $onehot(~dig_s2);
    sel   = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (!dig_s2[i]) sel = SELW'(i);
    end
    if (legal && seg_s2 == seg_prev && dig_s2 == dig_prev) begin
      cnt_nx = (cnt == 8'(STABLE)) ? cnt : cnt + 8'd1;
    end else begin
      cnt_nx = legal ? 8'd1 : 8'd0;
    end
    hit = (cnt_nx == 8'(STABLE)) && (cnt != 8'(STABLE));
  end

  seg7_pattern_decode u_decode (
    .pattern (seg_s2),
    .result  (dec)
  );

  // The capture is staged one cycle so the shadow write lands at edge 2+STABLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      cap_vld <= 1'b0;
      cap_sel <= '0;
      cap_res <= '0;
    end else begin
      cnt     <= cnt_nx;
      cap_vld <= hit;
      if (hit) begin
        cap_sel <= sel;
        cap_res <= dec;
      end
    end
  end

  assign frame_done = &seen;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seen         <= '0;
      shadow_val   <= '0;
      shadow_blank <= '0;
      shadow_err   <= '0;
    end else begin
      seen <= (frame_done ? '0 : seen) | (cap_vld ? (NDIG'(1) << cap_sel) : '0);
      if (cap_vld) begin
        shadow_val[int'(cap_sel)*4 +: 4] <= cap_res.nibble;
        shadow_blank[cap_sel]            <= cap_res.blank;
        shadow_err[cap_sel]              <= cap_res.err;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_EMPTY;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    ovr_nx   = overrun_q;
    case (state)
      ST_EMPTY: begin
        if (frame_done) begin
          load     = 1'b1;
          state_nx = ST_FULL;
        end
      end
      ST_FULL: begin
        if (fr.frame_ack) begin
          ovr_nx = 1'b0;
          if (frame_done) load = 1'b1;
          else            state_nx = ST_EMPTY;
        end else if (frame_done) begin
          ovr_nx = 1'b1;
        end
      end
      default: state_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value_q   <= '0;
      blank_q   <= '0;
      err_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= ovr_nx;
      if (load) begin
        value_q <= shadow_val;
        blank_q <= shadow_blank;
        err_q   <= shadow_err;
      end
    end
  end

  assign fr.value     = value_q;
  assign fr.blank     = blank_q;
  assign fr.err       = err_q;
  assign fr.overrun   = overrun_q;
  assign fr.frame_vld = (state == ST_FULL);
  assign fr.state     = state;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: frames are queued as they are scanned
// and a negedge monitor checks each frame the DUT presents.
module tb_seg7_scan_decoder;

  localparam int NDIG = 4;
  localparam int FW   = 6 * NDIG;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0011000;
  localparam logic [6:0] PA = 7'b0001000;
  localparam logic [6:0] PB = 7'b0000011;
  localparam logic [6:0] PC = 7'b1000110;
  localparam logic [6:0] PD = 7'b0100001;
  localparam logic [6:0] PE = 7'b0000110;
  localparam logic [6:0] PF = 7'b0001110;

  logic            clk = 1'b0;
  logic            resetn;
  logic [6:0]      seg_n;
  logic [NDIG-1:0] dig_n;

  int errors = 0;
  int checks = 0;
  logic [FW-1:0] exp_q[$];

  seg7_scan_decoder_if #(.NDIG(NDIG)) fr ();

  seg7_scan_decoder #(.NDIG(NDIG), .STABLE(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .seg_n  (seg_n),
    .dig_n  (dig_n),
    .fr     (fr)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input int d, input logic [6:0] pat, input int n);
    logic [NDIG-1:0] m;
    m     = NDIG'(1) << d;
    dig_n = ~m;
    seg_n = pat;
    tick(n);
  endtask

  task automatic idle(input int n);
    dig_n = '1;
    seg_n = '1;
    tick(n);
  endtask

  task automatic ack_pulse();
    fr.frame_ack = 1'b1;
    tick(1);
    fr.frame_ack = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: a frame is presented when frame_vld rises, or stays
  // high across an edge that accepted the previous frame
  logic vld_prev = 1'b0;
  logic ack_prev = 1'b0;
  logic [FW-1:0] exp_frame;

  always @(negedge clk) begin
    if (!resetn) begin
      vld_prev = 1'b0;
      ack_prev = 1'b0;
    end else begin
      if (fr.frame_vld && (!vld_prev || ack_prev)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %0h expected none", {fr.err, fr.blank, fr.value});
        end else begin
          exp_frame = exp_q.pop_front();
          check("frame", 32'({fr.err, fr.blank, fr.value}), 32'(exp_frame));
        end
      end
      vld_prev = fr.frame_vld;
      ack_prev = fr.frame_ack;
    end
  end

  initial begin
    resetn       = 1'b0;
    seg_n        = '1;
    dig_n        = '1;
    fr.frame_ack = 1'b0;
    tick(3);
    check("rst_vld", 32'(fr.frame_vld), 0);
    check("rst_value", 32'(fr.value), 0);
    check("rst_blank", 32'(fr.blank), 0);
    check("rst_err", 32'(fr.err), 0);
    check("rst_overrun", 32'(fr.overrun), 0);
    check("rst_state", 32'(fr.state), 0);
    resetn = 1'b1;
    idle(3);

    // basic frame, ack held low
    exp_q.push_back({4'b0000, 4'b0000, 16'h5432});
    show(0, P2, 8);
    show(1, P3, 8);
    show(2, P4, 8);
    show(3, P5, 8);
    idle(3);
    check("basic_vld", 32'(fr.frame_vld), 1);
    ack_pulse();
    check("basic_ack_vld", 32'(fr.frame_vld), 0);
    idle(2);

    // short hold is not captured; an exact STABLE hold is, with fixed latency
    show(0, P0, 8);
    show(1, P1, 3);
    show(2, P2, 8);
    show(3, P3, 8);
    idle(6);
    check("short_hold_vld", 32'(fr.frame_vld), 0);
    exp_q.push_back({4'b0000, 4'b0000, 16'h3210});
    show(1, P1, 4);
    idle(3);
    check("latency_edge6_vld", 32'(fr.frame_vld), 0);
    tick(1);
    check("latency_edge7_vld", 32'(fr.frame_vld), 1);
    ack_pulse();
    idle(2);

    // blank and error digits
    exp_q.push_back({4'b1000, 4'b0100, 16'h00A8});
    show(0, P8, 8);
    show(1, PA, 8);
    show(2, 7'b1111111, 8);
    show(3, 7'b1010101, 8);
    idle(3);
    check("blank_err_vld", 32'(fr.frame_vld), 1);
    ack_pulse();
    idle(2);

    // overrun: second frame dropped, first retained
    exp_q.push_back({4'b0000, 4'b0000, 16'hCDEF});
    show(0, PF, 8);
    show(1, PE, 8);
    show(2, PD, 8);
    show(3, PC, 8);
    show(0, P9, 8);
    show(1, P8, 8);
    show(2, P7, 8);
    show(3, P6, 8);
    idle(3);
    check("ovr_vld", 32'(fr.frame_vld), 1);
    check("ovr_flag", 32'(fr.overrun), 1);
    check("ovr_value_kept", 32'(fr.value), 32'h0000CDEF);
    ack_pulse();
    check("ovr_ack_vld", 32'(fr.frame_vld), 0);
    check("ovr_ack_flag", 32'(fr.overrun), 0);
    idle(2);

    // ack on the very edge the next frame completes
    exp_q.push_back({4'b0000, 4'b0000, 16'h321B});
    show(0, PB, 8);
    show(1, P1, 8);
    show(2, P2, 8);
    show(3, P3, 8);
    idle(2);
    exp_q.push_back({4'b0000, 4'b0000, 16'h7654});
    show(0, P4, 8);
    show(1, P5, 8);
    show(2, P6, 8);
    show(3, P7, 7);
    ack_pulse();
    check("ackcomp_vld", 32'(fr.frame_vld), 1);
    check("ackcomp_ovr", 32'(fr.overrun), 0);
    check("ackcomp_value", 32'(fr.value), 32'h00007654);
    idle(3);

    // illegal double enable never captures; then reset mid-frame
    show(1, PA, 8);
    show(2, PB, 8);
    show(3, PC, 8);
    dig_n = 4'b1100;
    seg_n = P8;
    tick(20);
    check("illegal_vld", 32'(fr.frame_vld), 1);
    check("illegal_ovr", 32'(fr.overrun), 0);
    check("illegal_value", 32'(fr.value), 32'h00007654);
    resetn = 1'b0;
    #2;
    check("midrst_vld", 32'(fr.frame_vld), 0);
    check("midrst_value", 32'(fr.value), 0);
    check("midrst_ovr", 32'(fr.overrun), 0);
    dig_n = '1;
    seg_n = '1;
    tick(2);
    #2;
    resetn = 1'b1;
    tick(2);
    check("postrst_state", 32'(fr.state), 0);
    show(0, P7, 8);
    idle(4);
    check("partial_discard_vld", 32'(fr.frame_vld), 0);
    exp_q.push_back({4'b0000, 4'b0000, 16'h1097});
    show(1, P9, 8);
    show(2, P0, 8);
    show(3, P1, 8);
    idle(2);
    check("postrst_frame_vld", 32'(fr.frame_vld), 1);
    tick(5);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Observes a multiplexed active-low 7-segment display bus (segment lines plus per-digit enables) and decodes it back into hex nibbles. It is the receiving end of our hex-to-segment encoding, used as an on-board display snooper and as a self-check monitor. Stable per-digit patterns are captured into a shadow frame. A complete frame is presented on a VALID/ACK handshake with blank, error and overrun flags.

Parameters:
NDIG, 4, number of scanned digits (1..8)
STABLE, 4, consecutive identical synchronized samples required before a digit is captured (2..255)

Ports:
CLK  in  1  system clock
RESETN  in  1  asynchronous active-low reset
SEG_N  in  7  segment lines, active-low, bit0=a .. bit6=g, asynchronous to CLK
DIG_N  in  NDIG  digit enables, active-low, one-hot when driving, asynchronous to CLK
VALUE  out  4*NDIG  decoded nibbles, digit i in bits [4i+3:4i]
BLANK  out  NDIG  digit i showed all segments off
ERR  out  NDIG  digit i showed a non-hex pattern
FRAME_VLD  out  1  complete frame held on VALUE/BLANK/ERR
FRAME_ACK  in  1  consumer accepts the frame
OVERRUN  out  1  a completed frame was dropped while FRAME_VLD was high

Behaviour:
- Reset (async assert, sync release): VALUE=0, BLANK=0, ERR=0, FRAME_VLD=0, OVERRUN=0. Synchronizers are set to all-ones (idle). Stability counter=0, seen mask=0, shadow frame=0.
- SEG_N and DIG_N each pass through a 2-flop synchronizer. All logic below uses the synchronized values.
- Stability: a sample is "legal" when exactly one DIG_N bit is low.
  - Legal and identical (SEG_N, DIG_N) to the previous sample: the counter increments, saturating at STABLE.
  - Otherwise the counter loads 1 if the sample is legal, else 0.
  - All-ones DIG_N is idle. More than one low bit is illegal. Neither ever captures.
- Capture: on the cycle the counter becomes STABLE (once per stable run), the decoded result is written to shadow slot sel and seen[sel] is set.
  - If the same digit is captured twice within a frame, the later capture overwrites the earlier one.
- Decode, on the pattern exactly as on the wire (g..a order):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - 1111111 gives nibble 0 with BLANK=1.
  - Any other pattern gives nibble 0 with ERR=1.
- Frame complete: when seen becomes all-ones, on the next edge the output FSM acts and seen is cleared.
- Output FSM, two states:
  - EMPTY: on frame complete, load outputs from the shadow frame, set FRAME_VLD=1, go to FULL.
  - FULL with FRAME_ACK=1 and no completion: FRAME_VLD=0, go to EMPTY.
  - FULL with FRAME_ACK=1 and a completion in the same cycle: load the new frame, stay FULL, no overrun.
  - FULL with FRAME_ACK=0 and a completion: keep the held frame, drop the new one, set OVERRUN.
- OVERRUN is sticky and is cleared on the cycle FRAME_ACK is accepted.
- FRAME_ACK while EMPTY is ignored.
- Latency: a digit pattern first present at the pins at edge 0 and held is captured at edge 2+STABLE. If it completes the frame, FRAME_VLD rises at edge 3+STABLE.
- Reset asserted mid-frame discards the partial frame and any held frame immediately.

Decomposition:
- Shared package seg7_pkg:
  - the 16 segment constants SEG_HEX_0..SEG_HEX_F and SEG_BLANK (7'b1111111)
  - segment bit-order constants
  - default NDIG
- One natural sub-module: seg7_pattern_decode, combinational, 7-bit pattern to {nibble, blank, err}. It is used once on the synchronized SEG_N.
- Synchronizers, counter, seen mask and output FSM stay in the top module.

Test Plan:
- NDIG=4, STABLE=4. Scan digits 0..3 with 0100100, 0110000, 0011001, 0010010, 8 cycles each, ACK tied 0 -> FRAME_VLD=1, VALUE=16'h5432, BLANK=0, ERR=0.
- Digit 1 held only 3 cycles, others 8 cycles -> no FRAME_VLD until digit 1 is later held ≥4 cycles. Holding exactly 4 cycles captures; FRAME_VLD rises 7 cycles after that pattern appeared.
- Digit 2 shows 1111111 and digit 3 shows 1010101 -> BLANK=4'b0100, ERR=4'b1000, corresponding nibbles 0.
- Two frames completed without ACK -> first frame retained, OVERRUN=1. Pulse ACK -> FRAME_VLD=0, OVERRUN=0 next cycle.
- ACK pulsed on the exact cycle the next frame completes -> FRAME_VLD stays 1, VALUE updates, OVERRUN stays 0.
- DIG_N=4'b1100 (two enables) held 20 cycles, then RESETN pulsed low mid-frame -> no capture during the illegal hold. The reset drives all outputs to 0 immediately, and the next frame requires all 4 digits again.
